rle_encoder: RTL

Run-length encoder sitting directly downstream of the sampler: consumes `smpls`/`stb` pairs and emits SUMP-compatible RLE words toward the capture memory controller. Literal samples are emitted with MSB cleared; repeat counts are emitted with MSB set. When disabled, the block is a one-cycle registered pass-through. A 2-entry output queue absorbs the double word produced on a value change, so no back-pressure toward the sampler is needed.

---
 rtl/logip_pkg.sv | 29 ++
 rtl/rle_outq.sv | 69 ++++++
 rtl/rle_encoder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/logip_pkg.sv
// Shared logic-analyser definitions: RLE flag position and literal/count word builder.
// Used by the RLE encoder, the capture memory controller and the host-side decoder tests.
// Words are built in a 64-bit container and truncated to the channel width by the user.
package logip_pkg;

  // Widest channel count the helpers below can build words for.
  localparam int RLE_MAX_CHLS = 64;

  typedef logic [RLE_MAX_CHLS-1:0] rle_word_t;

  typedef enum logic {
    RLE_LIT = 1'b0,
    RLE_CNT = 1'b1
  } rle_kind_t;

  // The top channel carries the literal/count flag when RLE is enabled.
  function automatic int rle_flag_bit(input int chls);
    return chls - 1;
  endfunction

  // Payload is masked to the bits below the flag, then the flag is set from kind.
  function automatic rle_word_t rle_word(input int chls, input rle_kind_t kind,
                                         input rle_word_t payload);
    rle_word_t mask;
    mask = (rle_word_t'(1) << rle_flag_bit(chls)) - rle_word_t'(1);
    return (payload & mask) | (rle_word_t'(kind) << rle_flag_bit(chls));
  endfunction

endpackage

// File: rtl/rle_outq.sv
// 2-entry fall-through output queue with ordered dual push and one pop per cycle.
// Latency: zero when empty (push0 is visible on head in the same cycle).
// Backpressure: none; the consumer always pops the head when it is valid.
// Ports: clk_i/rst_in clock and async active-low reset; push0/dat0 and push1/dat1
//        ordered pushes (push1 only with push0); head is the word popped this cycle;
//        empty reports that no word is stored.
module rle_outq #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_in,
  input  logic         push0,
  input  logic [W-1:0] dat0,
  input  logic         push1,
  input  logic [W-1:0] dat1,
  output logic [W-1:0] head,
  output logic         empty
);

  logic [W-1:0] mem0_q, mem1_q, mem0_d, mem1_d;
  logic [1:0]   cnt_q, cnt_d;

  assign empty = (cnt_q == 2'd0);
  // When nothing is stored the incoming word bypasses straight to the head.
  assign head  = empty ? dat0 : mem0_q;

  // The head is always popped when valid; the rest of {stored, dat0, dat1}
  // is compacted into the two slots.
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push1) begin
          mem0_d = dat1;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        mem0_d = dat0;
        mem1_d = dat1;
        cnt_d  = {1'b0, push0} + {1'b0, push1};
      end
      default: begin
        mem0_d = mem1_q;
        mem1_d = dat0;
        cnt_d  = 2'd1 + {1'b0, push0};
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      mem0_q <= '0;
      mem1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

  // A third stored word would be lost; push1 alone would reorder the pair.
  overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_in)
    !((cnt_q == 2'd2) && push1) && !(push1 && !push0));

endmodule

// File: rtl/rle_encoder.sv
// SUMP-style run-length encoder: literals with MSB clear, repeat counts with MSB set.
// Latency: one cycle to data_o; the second word of a count+literal pair follows a cycle later.
// Backpressure: none; the 2-entry output queue absorbs the double word on a value change.
// Ports: clk_i/rst_in clock and async active-low reset; en_i RLE enable (0 = pass-through);
//        flush_i closes the run; smpls_i/stb_i sample input; data_o/stb_o encoded output.
module rle_encoder
  import logip_pkg::*;
#(
  parameter int CHLS = 32
) (
  input  logic            clk_i,
  input  logic            rst_in,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic [CHLS-1:0] smpls_i,
  input  logic            stb_i,
  output logic [CHLS-1:0] data_o,
  output logic            stb_o
);

  localparam int W = CHLS - 1;
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0]    last_q, last_d, cnt_q, cnt_d, cnt_eff, cw_val;
  logic            have_q, have_d, have_eff, fpend_q, fpend_d, en_q;
  logic            cw_en, lit_en;
  logic [CHLS-1:0] cw_word, lit_rle, lit_word;
  logic            push0, push1, q_empty;
  logic [CHLS-1:0] dat0, q_head;

  assign cw_word = CHLS'(rle_word(CHLS, RLE_CNT, rle_word_t'(cw_val)));
  assign lit_rle = CHLS'(rle_word(CHLS, RLE_LIT, rle_word_t'(smpls_i)));

  always_comb begin
    last_d   = last_q;
    have_d   = have_q;
    cnt_d    = cnt_q;
    fpend_d  = 1'b0;
    have_eff = have_q;
    cnt_eff  = cnt_q;
    cw_en    = 1'b0;
    cw_val   = cnt_q;
    lit_en   = 1'b0;
    lit_word = lit_rle;
    if (!en_i) begin
      // Falling enable closes the run; a same-cycle strobe goes out after the count.
      cw_en    = en_q && (cnt_q != '0);
      lit_en   = stb_i;
      lit_word = smpls_i;
      last_d   = '0;
      have_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      // Flush (immediate or deferred from a flush+strobe cycle) happens before
      // any strobe in this cycle, so such a strobe starts a fresh run.
      if (fpend_q || (flush_i && !stb_i)) begin
        cw_en    = (cnt_q != '0);
        have_eff = 1'b0;
        cnt_eff  = '0;
      end
      have_d = have_eff;
      cnt_d  = cnt_eff;
      if (stb_i) begin
        fpend_d = flush_i;
        if (!have_eff) begin
          lit_en = 1'b1;
          last_d = smpls_i[W-1:0];
          have_d = 1'b1;
          cnt_d  = '0;
        end else if (smpls_i[W-1:0] == last_q) begin
          if (cnt_q + W'(1) == CNT_MAX) begin
            cw_en  = 1'b1;
            cw_val = CNT_MAX;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end else begin
          cw_en  = (cnt_q != '0);
          lit_en = 1'b1;
          last_d = smpls_i[W-1:0];
          cnt_d  = '0;
        end
      end
    end
  end

  // Count word always precedes the literal when both are produced.
  assign push0 = cw_en | lit_en;
  assign push1 = cw_en & lit_en;
  assign dat0  = cw_en ? cw_word : lit_word;

  rle_outq #(.W(CHLS)) u_outq (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .push0 (push0),
    .dat0  (dat0),
    .push1 (push1),
    .dat1  (lit_word),
    .head  (q_head),
    .empty (q_empty)
  );

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      last_q  <= '0;
      have_q  <= 1'b0;
      cnt_q   <= '0;
      fpend_q <= 1'b0;
      en_q    <= 1'b0;
      data_o  <= '0;
      stb_o   <= 1'b0;
    end else begin
      last_q  <= last_d;
      have_q  <= have_d;
      cnt_q   <= cnt_d;
      fpend_q <= fpend_d;
      en_q    <= en_i;
      stb_o   <= push0 || !q_empty;
      if (push0 || !q_empty) data_o <= q_head;
    end
  end

endmodule
